pipeline_ctrl: RTL and testbench

- Central sequencer for the 5-stage MIPS pipeline (IF, ID, EX, MEM, WB).
- Combines the hazard unit's load-use stall, I/D cache hit status, branch resolution and halt into per-latch enable and flush controls, plus PC enable.
- Gates the instruction-fetch request while a data access owns the shared memory port.
- Keeps saturating stall and flush performance counters.

---
 rtl/pipeline_ctrl.sv | 168 ++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer for the 5-stage MIPS core: latch enables/flushes, PC enable,
// fetch-port gating, sticky halt and saturating stall/flush performance counters.
module pipeline_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             hz_stall,
  input  logic             ihit,
  input  logic             dmem_req,
  input  logic             dhit,
  input  logic             br_taken,
  input  logic             halt_mem,
  output logic             pc_en,
  output logic             en_ifid,
  output logic             en_idex,
  output logic             en_exmem,
  output logic             en_memwb,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             flush_exmem,
  output logic             iren_gate,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DWAIT = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             data_wait_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      return v;
    end else begin
      return v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  assign data_wait_s = dmem_req & ~dhit;

  // Priority resolution of pipeline controls and next state.
  always_comb begin
    state_d     = ST_RUN;
    pc_en       = 1'b1;
    en_ifid     = 1'b1;
    en_idex     = 1'b1;
    en_exmem    = 1'b1;
    en_memwb    = 1'b1;
    flush_ifid  = 1'b0;
    flush_idex  = 1'b0;
    flush_exmem = 1'b0;
    iren_gate   = 1'b1;
    halted      = 1'b0;
    if (state_q == ST_HALT) begin
      state_d   = ST_HALT;
      pc_en     = 1'b0;
      en_ifid   = 1'b0;
      en_idex   = 1'b0;
      en_exmem  = 1'b0;
      en_memwb  = 1'b0;
      iren_gate = 1'b0;
      halted    = 1'b1;
    end else if (data_wait_s) begin
      // Whole pipe frozen, including any resolved branch in EX.
      state_d   = ST_DWAIT;
      pc_en     = 1'b0;
      en_ifid   = 1'b0;
      en_idex   = 1'b0;
      en_exmem  = 1'b0;
      en_memwb  = 1'b0;
      iren_gate = 1'b0;
    end else if (halt_mem) begin
      state_d  = ST_HALT;
      pc_en    = 1'b0;
      en_ifid  = 1'b0;
      en_idex  = 1'b0;
      en_exmem = 1'b0;
    end else if (br_taken) begin
      pc_en      = ihit;
      flush_ifid = 1'b1;
      flush_idex = 1'b1;
    end else if (hz_stall) begin
      pc_en      = 1'b0;
      en_ifid    = 1'b0;
      flush_idex = 1'b1;
    end else if (!ihit) begin
      pc_en      = 1'b0;
      flush_ifid = 1'b1;
    end else begin
      state_d = ST_RUN;
    end
  end

  // Next values of the saturating performance counters.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!pc_en && (state_q != ST_HALT)) begin
      stall_cnt_d = sat_inc(stall_cnt_q);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if (flush_ifid) begin
      flush_cnt_d = sat_inc(flush_cnt_q);
    end else begin
      flush_cnt_d = flush_cnt_q;
    end
  end

  // State and counter registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= ST_RUN;
      stall_cnt_q <= {CNT_W{1'b0}};
      flush_cnt_q <= {CNT_W{1'b0}};
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

  pipeline_ctrl_chk u_chk (
    .clk_i         (CLK),
    .rst_i         (RST),
    .pc_en_i       (pc_en),
    .en_ifid_i     (en_ifid),
    .en_idex_i     (en_idex),
    .en_exmem_i    (en_exmem),
    .en_memwb_i    (en_memwb),
    .flush_exmem_i (flush_exmem),
    .iren_gate_i   (iren_gate),
    .halted_i      (halted)
  );

endmodule

// Invariant checker: reserved flush stays low and a halted pipe is fully frozen.
module pipeline_ctrl_chk (
  input logic clk_i,
  input logic rst_i,
  input logic pc_en_i,
  input logic en_ifid_i,
  input logic en_idex_i,
  input logic en_exmem_i,
  input logic en_memwb_i,
  input logic flush_exmem_i,
  input logic iren_gate_i,
  input logic halted_i
);

  a_no_exmem_flush: assert property (@(posedge clk_i) disable iff (rst_i) !flush_exmem_i);

  a_halt_frozen: assert property (@(posedge clk_i) disable iff (rst_i)
    halted_i |-> !(pc_en_i | en_ifid_i | en_idex_i | en_exmem_i | en_memwb_i | iren_gate_i));

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: expected control vectors are queued as each
// step is driven and popped when the outputs are sampled; counters use CNT_W=4.
module tb_pipeline_ctrl;
  localparam int CW = 4;

  // {pc_en,en_ifid,en_idex,en_exmem,en_memwb,flush_ifid,flush_idex,flush_exmem,iren_gate,halted}
  localparam logic [9:0] O_NORM  = 10'b1111100010;
  localparam logic [9:0] O_WAIT  = 10'b0000000000;
  localparam logic [9:0] O_HZ    = 10'b0011101010;
  localparam logic [9:0] O_BR    = 10'b1111111010;
  localparam logic [9:0] O_BRMIS = 10'b0111111010;
  localparam logic [9:0] O_MISS  = 10'b0111110010;
  localparam logic [9:0] O_HMEM  = 10'b0000100010;
  localparam logic [9:0] O_HALT  = 10'b0000000001;

  // {hz_stall,ihit,dmem_req,dhit,br_taken,halt_mem}
  localparam logic [5:0] I_NORM  = 6'b010000;
  localparam logic [5:0] I_DWAIT = 6'b011000;
  localparam logic [5:0] I_DHIT  = 6'b011100;
  localparam logic [5:0] I_HZ    = 6'b110000;
  localparam logic [5:0] I_BRHZ  = 6'b110010;
  localparam logic [5:0] I_BRMIS = 6'b000010;
  localparam logic [5:0] I_MISS  = 6'b000000;
  localparam logic [5:0] I_BRWT  = 6'b011010;
  localparam logic [5:0] I_BRHIT = 6'b011110;
  localparam logic [5:0] I_HALT  = 6'b010001;

  logic CLK = 1'b0;
  logic RST;
  logic hz_stall, ihit, dmem_req, dhit, br_taken, halt_mem;
  logic pc_en, en_ifid, en_idex, en_exmem, en_memwb;
  logic flush_ifid, flush_idex, flush_exmem, iren_gate, halted;
  logic [CW-1:0] stall_cnt, flush_cnt;
  logic [9:0] obs;

  logic [9:0] sb_q[$];
  string      tag_q[$];
  int compared   = 0;
  int mismatched = 0;

  pipeline_ctrl #(.CNT_W(CW)) dut (
    .CLK(CLK), .RST(RST),
    .hz_stall(hz_stall), .ihit(ihit), .dmem_req(dmem_req), .dhit(dhit),
    .br_taken(br_taken), .halt_mem(halt_mem),
    .pc_en(pc_en), .en_ifid(en_ifid), .en_idex(en_idex), .en_exmem(en_exmem),
    .en_memwb(en_memwb), .flush_ifid(flush_ifid), .flush_idex(flush_idex),
    .flush_exmem(flush_exmem), .iren_gate(iren_gate), .halted(halted),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 CLK = ~CLK;

  assign obs = {pc_en, en_ifid, en_idex, en_exmem, en_memwb,
                flush_ifid, flush_idex, flush_exmem, iren_gate, halted};

  task automatic check_out();
    logic [9:0] e;
    string t;
    e = sb_q.pop_front();
    t = tag_q.pop_front();
    compared++;
    assert (obs === e) else begin
      mismatched++;
      $error("FAIL %s observed=%b expected=%b", t, obs, e);
    end
  endtask

  task automatic apply(input logic [5:0] in, input logic [9:0] e, input string t);
    @(negedge CLK);
    {hz_stall, ihit, dmem_req, dhit, br_taken, halt_mem} = in;
    sb_q.push_back(e);
    tag_q.push_back(t);
    #1;
    check_out();
  endtask

  task automatic chk_cnt(input string t, input int s, input int f);
    logic [CW-1:0] es, ef;
    es = CW'(s);
    ef = CW'(f);
    compared++;
    assert (stall_cnt === es) else begin
      mismatched++;
      $error("FAIL %s_stall observed=%0d expected=%0d", t, stall_cnt, es);
    end
    compared++;
    assert (flush_cnt === ef) else begin
      mismatched++;
      $error("FAIL %s_flush observed=%0d expected=%0d", t, flush_cnt, ef);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1;
    {hz_stall, ihit, dmem_req, dhit, br_taken, halt_mem} = I_NORM;
    apply(I_NORM, O_NORM, "rst_hold");
    chk_cnt("rst_hold", 0, 0);
    RST = 1'b0;
    apply(I_NORM, O_NORM, "rst_rel");
    chk_cnt("rst_rel", 0, 0);

    for (int i = 0; i < 3; i++) apply(I_DWAIT, O_WAIT, "dwait");
    apply(I_DHIT, O_NORM, "dhit");
    chk_cnt("dwait", 3, 0);

    apply(I_HZ, O_HZ, "hz");
    apply(I_NORM, O_NORM, "hz_after");
    chk_cnt("hz", 4, 0);

    apply(I_BRHZ, O_BR, "br_hz");
    apply(I_NORM, O_NORM, "br_after");
    chk_cnt("br_hz", 4, 1);

    apply(I_BRMIS, O_BRMIS, "br_miss");
    apply(I_MISS, O_MISS, "imiss");
    apply(I_NORM, O_NORM, "miss_after");
    chk_cnt("miss", 6, 3);

    for (int i = 0; i < 2; i++) apply(I_BRWT, O_WAIT, "br_dwait");
    apply(I_BRHIT, O_BR, "br_dhit");
    apply(I_NORM, O_NORM, "brd_after");
    chk_cnt("br_dwait", 8, 4);

    apply(I_DWAIT, O_WAIT, "dwait2");
    apply(I_HZ, O_HZ, "dwait_exit_hz");
    apply(I_NORM, O_NORM, "exit_after");
    chk_cnt("dwait_exit", 10, 4);

    apply(I_HALT, O_HMEM, "halt_mem");
    for (int i = 0; i < 10; i++)
      apply((i % 2 == 0) ? 6'b111111 : 6'b011000, O_HALT, "halted");
    chk_cnt("halt_frz", 11, 4);

    @(negedge CLK);
    RST = 1'b1;
    {hz_stall, ihit, dmem_req, dhit, br_taken, halt_mem} = I_NORM;
    sb_q.push_back(O_NORM);
    tag_q.push_back("rst_mid_halt");
    #1;
    check_out();
    chk_cnt("rst_mid_halt", 0, 0);
    RST = 1'b0;
    apply(I_NORM, O_NORM, "resume");

    for (int i = 0; i < (1 << CW) + 5; i++) apply(I_HZ, O_HZ, "sat_hz");
    apply(I_NORM, O_NORM, "sat_after");
    chk_cnt("sat_stall", 15, 0);
    for (int i = 0; i < (1 << CW) + 4; i++) apply(I_MISS, O_MISS, "sat_miss");
    apply(I_NORM, O_NORM, "sat2_after");
    chk_cnt("sat_flush", 15, 15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
